imem_loader: RTL and testbench

- Writer-side counterpart to the CPU result dump. Streams a program into the single-cycle CPU's instruction memory.
- Holds the CPU in reset while loading, then releases it so execution starts at PC 0 from a known image.
- Sits between the bench or host stimulus stream and the instruction-memory write port. Drives the CPU's active-low reset.

---
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a program image into instruction memory while the
// CPU is held in reset, then releases the CPU so it starts at PC 0.
//
// Ports:
//   clk_i, rst_i (async, active-low)       clock / reset
//   start_i                                pulse, begins a (re)load
//   s_valid_i, s_ready_o, s_data_i, s_last_i  image stream
//   imem_we_o, imem_addr_o, imem_wdata_o   instruction-memory write port
//   cpu_rst_o (active-low), done_o         CPU reset / running flag
//   words_o                                words written in this load
//   err_o                                  checksum/length error (optional)
//
// Optional feature: define LOADER_CHECKSUM_EN to treat the s_last_i word
// as a modular checksum of the image; a mismatch parks in ERROR.

module imem_loader #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_last_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [DATA_W-1:0] imem_wdata_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic [ADDR_W:0]   words_o
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic              err_o
`endif
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN
`ifdef LOADER_CHECKSUM_EN
      ,
      S_ERR
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q;
   logic [HW-1:0]     hold_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              crst_q;
   logic              done_q;

   logic hs;
   logic wr;
   logic at_end;
   logic term;
   logic go;

   assign hs     = s_valid_i & s_ready_o;
   // Address all-ones is the last slot; accepting it ends the load.
   assign at_end = (cnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}});
   assign term   = hs & (s_last_i | at_end);
   // Counters clear whenever a new load is entered.
   assign go     = (state_d == S_LOAD) & (state_q != S_LOAD);

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
   logic              err_q;
   logic              ck_ok;

   // The s_last_i word is the checksum and never reaches memory.
   assign wr    = hs & ~s_last_i;
   assign ck_ok = s_last_i & (sum_q == s_data_i);
`else
   assign wr    = hs;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start_i) state_d = S_LOAD;
         S_LOAD: begin
            if (term) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = ck_ok ? S_HOLD : S_ERR;
`else
               state_d = S_HOLD;
`endif
            end
         end
         S_HOLD: if (hold_q == '0) state_d = S_RUN;
         S_RUN:  if (start_i) state_d = S_LOAD;
`ifdef LOADER_CHECKSUM_EN
         S_ERR:  if (start_i) state_d = S_LOAD;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      s_ready_o = 1'b0;
      if (state_q == S_LOAD) s_ready_o = 1'b1;
   end

   // Write port, word counter and hold timer
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         we_q <= wr;
         if (wr) begin
            addr_q  <= cnt_q[ADDR_W-1:0];
            wdata_q <= s_data_i;
         end
         if (go) begin
            cnt_q <= '0;
         end else if (wr) begin
            cnt_q <= cnt_q + (ADDR_W+1)'(1);
         end
         if (state_d == S_HOLD && state_q != S_HOLD) begin
            hold_q <= HW'(HOLD_CYCLES);
         end else if (state_q == S_HOLD && hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
         end
      end
   end

   // Flop-driven CPU reset so the release edge is glitch-free.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         crst_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         crst_q <= (state_d == S_RUN);
         done_q <= (state_d == S_RUN);
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (go) begin
            sum_q <= '0;
         end else if (wr) begin
            sum_q <= sum_q + s_data_i;
         end
         err_q <= (state_d == S_ERR);
      end
   end

   assign err_o = err_q;
`endif

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_rst_o    = crst_q;
   assign done_o       = done_q;
   assign words_o      = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: two loaders (256-word and 4-word memories) share one
// stimulus stream and are checked every cycle against a behavioural model.

module tb_imem_loader;

   localparam int H0 = 4;
   localparam int H1 = 2;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_HOLD = 2;
   localparam int P_RUN  = 3;
   localparam int P_ERR  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        valid = 1'b0;
   logic        last = 1'b0;
   logic [31:0] data = '0;

   always #5 clk = ~clk;

   logic        rdy0, we0, crst0, done0, err0;
   logic [7:0]  addr0;
   logic [31:0] wd0;
   logic [8:0]  words0;
   logic        rdy1, we1, crst1, done1, err1;
   logic [1:0]  addr1;
   logic [31:0] wd1;
   logic [2:0]  words1;

   imem_loader #(.ADDR_W(8), .DATA_W(32), .HOLD_CYCLES(H0)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start),
      .s_valid_i(valid), .s_ready_o(rdy0), .s_data_i(data),
      .s_last_i(last), .imem_we_o(we0), .imem_addr_o(addr0),
      .imem_wdata_o(wd0), .cpu_rst_o(crst0), .done_o(done0),
      .words_o(words0)
`ifdef LOADER_CHECKSUM_EN
      , .err_o(err0)
`endif
   );

   imem_loader #(.ADDR_W(2), .DATA_W(32), .HOLD_CYCLES(H1)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start),
      .s_valid_i(valid), .s_ready_o(rdy1), .s_data_i(data),
      .s_last_i(last), .imem_we_o(we1), .imem_addr_o(addr1),
      .imem_wdata_o(wd1), .cpu_rst_o(crst1), .done_o(done1),
      .words_o(words1)
`ifdef LOADER_CHECKSUM_EN
      , .err_o(err1)
`endif
   );

`ifndef LOADER_CHECKSUM_EN
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int i,
                      input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %0h want %0h", nm, i, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cap [2] = '{256, 4};
   int          hold [2] = '{H0, H1};
   int          ph [2];
   int          m_words [2];
   bit          m_we [2];
   int          m_addr [2];
   logic [31:0] m_wd [2];
   bit          m_crst [2];
   bit          m_done [2];
   bit          m_err [2];
   logic [31:0] m_sum [2];
   longint      m_rel [2];
   longint      cyc;
   bit          hs, isck, term;
   logic [31:0] s0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0;
         for (int i = 0; i < 2; i++) begin
            ph[i] = P_IDLE; m_words[i] = 0; m_we[i] = 0;
            m_addr[i] = 0; m_wd[i] = '0; m_crst[i] = 0;
            m_done[i] = 0; m_err[i] = 0; m_sum[i] = '0; m_rel[i] = 0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            hs = valid && (ph[i] == P_LOAD);
            m_we[i] = 0;
            if (ph[i] == P_LOAD) begin
               if (hs) begin
                  isck = CK && last;
                  term = last || (m_words[i] == cap[i] - 1);
                  s0 = m_sum[i];
                  if (!isck) begin
                     m_we[i] = 1; m_addr[i] = m_words[i]; m_wd[i] = data;
                     m_words[i]++; m_sum[i] = m_sum[i] + data;
                  end
                  if (term) begin
                     if (!CK || (last && s0 == data)) begin
                        ph[i] = P_HOLD; m_rel[i] = cyc + hold[i] + 1;
                     end else begin
                        ph[i] = P_ERR; m_err[i] = 1;
                     end
                  end
               end
            end else if (ph[i] == P_HOLD) begin
               if (cyc == m_rel[i]) begin
                  ph[i] = P_RUN; m_crst[i] = 1; m_done[i] = 1;
               end
            end else if (start) begin
               ph[i] = P_LOAD; m_words[i] = 0; m_sum[i] = '0;
               m_crst[i] = 0; m_done[i] = 0; m_err[i] = 0;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   typedef struct { longint c; int a; logic [31:0] d; } wr_t;
   wr_t wq0 [$];
   int  nw1 = 0;

   longint g_rdy [2], g_we [2], g_addr [2], g_wd [2];
   longint g_crst [2], g_done [2], g_words [2], g_err [2];

   always @(negedge clk) begin
      g_rdy = '{rdy0, rdy1};     g_we = '{we0, we1};
      g_addr = '{addr0, addr1};  g_wd = '{wd0, wd1};
      g_crst = '{crst0, crst1};  g_done = '{done0, done1};
      g_words = '{words0, words1}; g_err = '{err0, err1};
      for (int i = 0; i < 2; i++) begin
         chk("s_ready", i, g_rdy[i], longint'(ph[i] == P_LOAD));
         chk("imem_we", i, g_we[i], longint'(m_we[i]));
         if (m_we[i] || !rst_n) begin
            chk("imem_addr", i, g_addr[i], m_addr[i]);
            chk("imem_wdata", i, g_wd[i], m_wd[i]);
         end
         chk("cpu_rst", i, g_crst[i], longint'(m_crst[i]));
         chk("done", i, g_done[i], longint'(m_done[i]));
         chk("words", i, g_words[i], m_words[i]);
         if (CK) chk("err", i, g_err[i], longint'(m_err[i]));
      end
      if (we0) wq0.push_back('{cyc, int'(addr0), wd0});
      if (we1) nw1++;
   end

   // ---------------- stimulus ----------------
   task automatic cy(input bit st, input bit v,
                     input logic [31:0] d, input bit l);
      start = st; valid = v; data = d; last = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cy(0, 0, 32'h0, 0);
   endtask

   localparam logic [31:0] W0 = 32'h20010005;
   localparam logic [31:0] W1 = 32'h20020007;
   localparam logic [31:0] W2 = 32'h00221820;

   int b, b1, r0, r1;

   initial begin
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_words", 0, words0, 0);
      chk("rst_cpu_rst", 0, crst0, 0);
      chk("rst_we", 1, we1, 0);
      rst_n = 1'b1;

      // back-to-back image
      b = wq0.size();
      cy(1, 0, 0, 0);
      cy(0, 1, W0, 0); cy(0, 1, W1, 0); cy(0, 1, W2, 1);
      r0 = -1; r1 = -1;
      for (int j = 1; j <= 10; j++) begin
         cy(0, 0, 0, 0);
         if (crst0 && r0 < 0) r0 = j;
         if (crst1 && r1 < 0) r1 = j;
      end
      if (!CK) begin
         chk("t1_rise", 0, r0, H0 + 1);
         chk("t1_rise", 1, r1, H1 + 1);
         chk("t1_words", 0, words0, 3);
         chk("t1_done", 0, done0, 1);
         chk("t1_nwr", 0, wq0.size() - b, 3);
         if (wq0.size() - b == 3) begin
            chk("t1_a2", 0, wq0[b+2].a, 2);
            chk("t1_d2", 0, wq0[b+2].d, W2);
            chk("t1_b2b", 0, wq0[b+2].c - wq0[b].c, 2);
         end
      end else begin
         chk("t1_err", 0, err0, 1);
      end

      // gapped valid
      b = wq0.size();
      cy(1, 0, 0, 0);
      cy(0, 1, W0, 0); cy(0, 0, W1, 0); cy(0, 1, W1, 0);
      cy(0, 0, W2, 0); cy(0, 1, W2, 1);
      idle(8);
      if (!CK) begin
         chk("t2_nwr", 0, wq0.size() - b, 3);
         if (wq0.size() - b == 3)
            chk("t2_gap", 0, wq0[b+1].c - wq0[b].c, 2);
      end

      // reload from RUN with one word
      b = wq0.size();
      cy(1, 0, 0, 0);
      chk("t3_cpu_rst", 0, crst0, 0);
      cy(0, 1, 32'hFFFFFFFF, 1);
      idle(8);
      if (!CK) begin
         chk("t3_words", 0, words0, 1);
         chk("t3_run", 0, crst0, 1);
         if (wq0.size() - b == 1)
            chk("t3_a0", 0, wq0[b].a, 0);
         else
            chk("t3_nwr", 0, wq0.size() - b, 1);
      end

      // over-length on the 4-word loader
      b1 = nw1;
      cy(1, 0, 0, 0);
      for (int k = 0; k < 6; k++) cy(0, 1, 32'(k + 1), 0);
      chk("t4_nwr", 1, nw1 - b1, 4);
      chk("t4_words", 1, words1, 4);
      chk("t4_ready", 1, rdy1, 0);
      if (CK) chk("t4_err", 1, err1, 1);
      cy(0, 1, 32'h7, 1);
      idle(8);

      // reset mid-load
      cy(1, 0, 0, 0);
      cy(0, 1, W0, 0); cy(0, 1, W1, 0);
      valid = 1; data = W2;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_we", 0, we0, 0);
      chk("t5_words", 0, words0, 0);
      chk("t5_addr", 0, addr0, 0);
      chk("t5_ready", 0, rdy0, 0);
      chk("t5_cpu_rst", 1, crst1, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b = wq0.size(); b1 = nw1;
      for (int k = 0; k < 4; k++) cy(0, 1, 32'hABCD0000 + k, k == 3);
      chk("t5_nowr", 0, wq0.size() - b, 0);
      chk("t5_nowr", 1, nw1 - b1, 0);
      chk("t5_held", 0, crst0, 0);

`ifdef LOADER_CHECKSUM_EN
      cy(1, 0, 0, 0);
      cy(0, 1, 1, 0); cy(0, 1, 2, 0); cy(0, 1, 3, 1);
      idle(8);
      chk("ck_words", 0, words0, 2);
      chk("ck_done", 0, done0, 1);
      chk("ck_err", 0, err0, 0);
      cy(1, 0, 0, 0);
      cy(0, 1, 1, 0); cy(0, 1, 2, 0); cy(0, 1, 4, 1);
      idle(8);
      chk("ck_bad_err", 0, err0, 1);
      chk("ck_bad_rst", 0, crst0, 0);
`endif

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(199) == 0) begin
            #2;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         cy($urandom_range(15) == 0, $urandom_range(2) != 0,
            $urandom(), $urandom_range(9) == 0);
      end
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
